// File: rtl/computie_bus_trigger_snooper.sv
// rtl/computie_bus_trigger_snooper.sv - Computie bus snooper with trigger-frozen circular trace and byte dump
// Captures bus cycles while armed, freezes post_count entries after a trigger, and replays oldest-first.
module computie_bus_trigger_snooper #(
  parameter int BITWIDTH = 32,
  parameter int DEPTH    = 8,
  parameter int PW       = $clog2(DEPTH)
) (
  input  logic                comm_clock,
  input  logic                comm_reset,
  input  logic                arm,
  input  logic                trigger_ext,
  input  logic [BITWIDTH-1:0] trig_match,
  input  logic [BITWIDTH-1:0] trig_mask,
  input  logic [PW-1:0]       post_count,
  output logic                armed,
  output logic                triggered,
  output logic                done,
  output logic [PW:0]         entry_count,
  input  logic                dump_start,
  output logic                dump_end,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [7:0]          out_data,
  input  logic                cb_addr_strobe,
  input  logic                cb_data_strobe,
  input  logic                cb_read_write,
  input  logic [BITWIDTH-1:0] cb_addr_data_bus
);

  localparam int NB = 1 + 2 * BITWIDTH / 8;
  localparam int BW = $clog2(NB);

  typedef enum logic [2:0] {IDLE, ARMED, POST, DONE, DUMP} state_t;
  state_t state, next_state;

  logic as_s1, as_s2, as_d, ds_s1, ds_s2, ds_d, rw_s1, rw_s2;
  logic [BITWIDTH-1:0] lat_addr, lat_data;
  logic lat_rw, got_data, have_addr, ext_seen, wr_pend;
  logic [BITWIDTH-1:0] mem_addr [DEPTH];
  logic [BITWIDTH-1:0] mem_data [DEPTH];
  logic [1:0]          mem_flag [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, remain;
  logic [PW:0]   ent_left;
  logic [BW-1:0] byte_idx;
  logic [8*NB-1:0] entry_vec;

  logic as_fall, as_rise, ds_fall, arm_ok, capturing, do_write;
  logic addr_hit, is_trig, dump_go, accept, last_byte;

  assign as_fall   = as_d & ~as_s2;
  assign as_rise   = ~as_d & as_s2;
  assign ds_fall   = ds_d & ~ds_s2;
  assign arm_ok    = arm && (state != DUMP);
  assign capturing = (state == ARMED) || (state == POST);
  assign do_write  = wr_pend && capturing && !arm_ok;
  assign addr_hit  = (((lat_addr ^ trig_match) & trig_mask) == '0) && (trig_mask != '0);
  assign is_trig   = addr_hit || ext_seen || trigger_ext;
  assign dump_go   = (state == DONE) && dump_start && !arm;
  assign accept    = (state == DUMP) && out_ready;
  assign last_byte = accept && (byte_idx == BW'(NB - 1)) && (ent_left == (PW+1)'(1));

  assign armed     = capturing;
  assign done      = (state == DONE);
  assign out_valid = (state == DUMP);

  always_ff @(posedge comm_clock or negedge comm_reset) begin
    if (!comm_reset) state <= IDLE;
    else             state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (arm_ok) next_state = ARMED;
      ARMED: if (arm_ok) next_state = ARMED;
             else if (do_write && is_trig) next_state = (post_count == '0) ? DONE : POST;
      POST:  if (arm_ok) next_state = ARMED;
             else if (do_write && remain == PW'(1)) next_state = DONE;
      DONE:  if (arm_ok) next_state = ARMED;
             else if (dump_go && entry_count != '0) next_state = DUMP;
      DUMP:  if (last_byte) next_state = DONE;
      default: next_state = IDLE;
    endcase
  end

  // Strobes idle high, so the synchronisers reset to 1 to avoid a false edge.
  always_ff @(posedge comm_clock or negedge comm_reset) begin
    if (!comm_reset) begin
      {as_s1, as_s2, as_d, ds_s1, ds_s2, ds_d} <= 6'b111111;
      {rw_s1, rw_s2} <= 2'b00;
      lat_addr <= '0; lat_data <= '0; lat_rw <= 1'b0;
      got_data <= 1'b0; have_addr <= 1'b0; ext_seen <= 1'b0; wr_pend <= 1'b0;
    end else begin
      as_s1 <= cb_addr_strobe; as_s2 <= as_s1; as_d <= as_s2;
      ds_s1 <= cb_data_strobe; ds_s2 <= ds_s1; ds_d <= ds_s2;
      rw_s1 <= cb_read_write;  rw_s2 <= rw_s1;
      if (as_fall) begin
        lat_addr <= cb_addr_data_bus;
        lat_rw   <= rw_s2;
        got_data <= 1'b0;
        ext_seen <= trigger_ext;
      end else begin
        ext_seen <= ext_seen | trigger_ext;
        if (ds_fall && !as_s2) begin
          lat_data <= cb_addr_data_bus;
          got_data <= 1'b1;
        end
      end
      // A cycle only counts if its address was latched after the most recent arm.
      if (arm_ok)       have_addr <= 1'b0;
      else if (as_fall) have_addr <= 1'b1;
      else if (as_rise) have_addr <= 1'b0;
      wr_pend <= as_rise && have_addr && !arm_ok;
    end
  end

  always_ff @(posedge comm_clock) begin
    if (do_write) begin
      mem_addr[wr_ptr] <= lat_addr;
      mem_data[wr_ptr] <= got_data ? lat_data : '0;
      mem_flag[wr_ptr] <= {got_data, lat_rw};
    end
  end

  always_ff @(posedge comm_clock or negedge comm_reset) begin
    if (!comm_reset) begin
      wr_ptr <= '0; entry_count <= '0; remain <= '0; triggered <= 1'b0;
      rd_ptr <= '0; ent_left <= '0; byte_idx <= '0; dump_end <= 1'b0;
    end else begin
      dump_end <= 1'b0;
      if (arm_ok) begin
        wr_ptr <= '0; entry_count <= '0; triggered <= 1'b0;
      end else if (do_write) begin
        wr_ptr <= wr_ptr + PW'(1);
        if (entry_count != (PW+1)'(DEPTH)) entry_count <= entry_count + (PW+1)'(1);
        if (state == ARMED && is_trig) begin
          triggered <= 1'b1;
          remain    <= post_count;
        end else if (state == POST) begin
          remain <= remain - PW'(1);
        end
      end
      if (dump_go) begin
        // A full buffer gives rd_ptr == wr_ptr, which is the oldest entry.
        rd_ptr   <= wr_ptr - entry_count[PW-1:0];
        ent_left <= entry_count;
        byte_idx <= '0;
        dump_end <= (entry_count == '0);
      end else if (accept) begin
        if (byte_idx == BW'(NB - 1)) begin
          byte_idx <= '0;
          rd_ptr   <= rd_ptr + PW'(1);
          ent_left <= ent_left - (PW+1)'(1);
          dump_end <= (ent_left == (PW+1)'(1));
        end else begin
          byte_idx <= byte_idx + BW'(1);
        end
      end
    end
  end

  always_comb begin
    entry_vec = {6'b0, ~mem_flag[rd_ptr][1], mem_flag[rd_ptr][0], mem_addr[rd_ptr], mem_data[rd_ptr]};
    out_data  = 8'h00;
    if (state == DUMP) begin
      for (int k = 0; k < NB; k++) begin
        if (byte_idx == BW'(k)) out_data = entry_vec[(NB-1-k)*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_computie_bus_trigger_snooper.sv
// tb/tb_computie_bus_trigger_snooper.sv - directed self-checking bench for computie_bus_trigger_snooper
module tb_computie_bus_trigger_snooper;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        arm = 1'b0, trig_ext = 1'b0, dump_start = 1'b0, out_ready = 1'b1;
  logic [31:0] trig_match = '0, trig_mask = '0, bus = '0;
  logic [2:0]  post_count = '0;
  logic        as_n = 1'b1, ds_n = 1'b1, rw = 1'b0;
  logic        armed, triggered, done, dump_end, out_valid;
  logic [3:0]  entry_count;
  logic [7:0]  out_data;

  int passed = 0, total = 0, failed = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] first_q[$];
  int ends;

  computie_bus_trigger_snooper dut (
    .comm_clock(clk), .comm_reset(rst_n), .arm(arm), .trigger_ext(trig_ext),
    .trig_match(trig_match), .trig_mask(trig_mask), .post_count(post_count),
    .armed(armed), .triggered(triggered), .done(done), .entry_count(entry_count),
    .dump_start(dump_start), .dump_end(dump_end), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .cb_addr_strobe(as_n),
    .cb_data_strobe(ds_n), .cb_read_write(rw), .cb_addr_data_bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_entry(input logic [7:0] flags, input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back(flags);
    for (int k = 3; k >= 0; k--) exp_q.push_back(a[k*8 +: 8]);
    for (int k = 3; k >= 0; k--) exp_q.push_back(d[k*8 +: 8]);
  endtask

  task automatic pulse_arm();
    @(negedge clk); arm = 1'b1;
    @(negedge clk); arm = 1'b0;
  endtask

  task automatic bus_cycle(input logic [31:0] a, input logic [31:0] d, input logic r,
                           input bit with_data, input bit ext);
    @(negedge clk); bus = a; rw = r; as_n = 1'b0;
    repeat (5) @(negedge clk);
    if (ext) begin
      trig_ext = 1'b1; @(negedge clk); trig_ext = 1'b0;
    end
    if (with_data) begin
      bus = d; ds_n = 1'b0;
      repeat (5) @(negedge clk);
      ds_n = 1'b1;
      repeat (3) @(negedge clk);
    end
    as_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // mode 0: always ready; mode 1: ready one cycle in three
  task automatic run_dump(input int mode);
    int tail;
    got_q.delete();
    ends = 0;
    tail = -1;
    @(negedge clk); dump_start = 1'b1;
    for (int cyc = 0; cyc < 2000 && tail != 0; cyc++) begin
      @(negedge clk);
      dump_start = 1'b0;
      if (dump_end) ends++;
      out_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
      if (out_valid && out_ready) got_q.push_back(out_data);
      if (tail > 0) tail--;
      else if (tail < 0 && ends > 0) tail = 4;
    end
    out_ready = 1'b1;
  endtask

  task automatic compare_dump(input string tag);
    int mism;
    mism = 0;
    check({tag, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) mism++;
    check({tag, "_byte_mismatches"}, 64'(mism), 64'd0);
    check({tag, "_dump_end_pulses"}, 64'(ends), 64'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_armed", armed, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_triggered", triggered, 1'b0);
    check("rst_entry_count", entry_count, 4'd0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_dump_end", dump_end, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // External trigger on the third write, no post-trigger entries
    trig_mask = '0; post_count = 3'd0;
    pulse_arm();
    check("t1_armed", armed, 1'b1);
    bus_cycle(32'h2020FFFF, 32'hAAAAAAAA, 1'b0, 1, 0);
    bus_cycle(32'h2020FFFE, 32'hAAAAAAAA, 1'b0, 1, 0);
    check("t1_not_done_yet", done, 1'b0);
    bus_cycle(32'h2020FFFD, 32'hAAAAAAAA, 1'b0, 1, 1);
    check("t1_done", done, 1'b1);
    check("t1_count", entry_count, 4'd3);
    check("t1_triggered", triggered, 1'b1);
    check("t1_armed_low", armed, 1'b0);
    exp_q.delete();
    push_entry(8'h00, 32'h2020FFFF, 32'hAAAAAAAA);
    push_entry(8'h00, 32'h2020FFFE, 32'hAAAAAAAA);
    push_entry(8'h00, 32'h2020FFFD, 32'hAAAAAAAA);
    run_dump(0);
    compare_dump("t1");
    check("t1_byte0", got_q.size() > 0 ? got_q[0] : 8'hxx, 8'h00);
    check("t1_byte1", got_q.size() > 1 ? got_q[1] : 8'hxx, 8'h20);
    check("t1_byte4", got_q.size() > 4 ? got_q[4] : 8'hxx, 8'hFF);
    check("t1_done_after_dump", done, 1'b1);

    // Cycle already in progress at arm is dropped; read with no data strobe
    @(negedge clk); bus = 32'h33333333; as_n = 1'b0;
    repeat (5) @(negedge clk);
    pulse_arm();
    repeat (3) @(negedge clk);
    as_n = 1'b1;
    repeat (6) @(negedge clk);
    check("t2_stray_not_recorded", entry_count, 4'd0);
    check("t2_still_armed", armed, 1'b1);
    bus_cycle(32'h0000BEEF, 32'h0, 1'b1, 0, 1);
    check("t2_done", done, 1'b1);
    check("t2_count", entry_count, 4'd1);
    exp_q.delete();
    push_entry(8'h03, 32'h0000BEEF, 32'h00000000);
    run_dump(0);
    compare_dump("t2");

    // Address-match trigger with two post-trigger entries
    trig_mask = 32'hFFFFFFFF; trig_match = 32'h00001005; post_count = 3'd2;
    pulse_arm();
    check("t3_triggered_cleared", triggered, 1'b0);
    for (int i = 0; i < 12; i++) begin
      bus_cycle(32'h1000 + 32'(i), 32'h5000 + 32'(i), 1'b0, 1, 0);
      if (i == 5) begin
        check("t3_post_armed", armed, 1'b1);
        check("t3_post_triggered", triggered, 1'b1);
        check("t3_post_not_done", done, 1'b0);
      end
    end
    check("t3_done", done, 1'b1);
    check("t3_count", entry_count, 4'd8);
    check("t3_triggered", triggered, 1'b1);
    exp_q.delete();
    for (int i = 0; i < 8; i++) push_entry(8'h00, 32'h1000 + 32'(i), 32'h5000 + 32'(i));
    run_dump(0);
    compare_dump("t3");

    // Wraparound, throttled consumer, re-dump
    trig_match = 32'd17; post_count = 3'd2;
    pulse_arm();
    @(negedge clk); dump_start = 1'b1;
    @(negedge clk); dump_start = 1'b0;
    @(negedge clk);
    check("t4_dump_ignored_armed", out_valid, 1'b0);
    for (int i = 0; i < 20; i++)
      bus_cycle(32'(i), 32'hD0000000 | 32'(i), 1'b0, 1, 0);
    check("t4_done", done, 1'b1);
    check("t4_count", entry_count, 4'd8);
    exp_q.delete();
    for (int i = 12; i < 20; i++) push_entry(8'h00, 32'(i), 32'hD0000000 | 32'(i));
    run_dump(1);
    compare_dump("t4_throttled");
    first_q = got_q;
    run_dump(0);
    compare_dump("t4_redump");

    // Reset asserted mid-dump
    @(negedge clk); dump_start = 1'b1;
    @(negedge clk); dump_start = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check("t5_dumping", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", out_valid, 1'b0);
    check("t5_rst_done", done, 1'b0);
    check("t5_rst_count", entry_count, 4'd0);
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk); dump_start = 1'b1;
    @(negedge clk); dump_start = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_dump_ignored_idle", out_valid, 1'b0);
    check("t5_idle_not_done", done, 1'b0);
    check("t5_idle_dump_end", dump_end, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
